microwave_panel_ctrl: RTL
=========================

Name: microwave_panel_ctrl

Overview:
Front-panel controller that sits directly upstream of the microwave timer/run stage and shares that stage's timer clock. It turns raw button and door inputs into the timer's 4-bit increment input (tin) and run-request level (r). It also watches the timer's run flag (p) to detect cook completion and drives a timed beep. All outputs are registered.

Parameters:
STEP, 4'd1, value presented on tin for one cycle per accepted "add" press
BEEP_CYCLES, 8, number of cycles beep stays high in DONE (1..255)
MAX_SET, 4'd15, saturation limit of the internal set-time shadow

Ports:
clk  in  1  single system clock, same clock as the timer registers
rst  in  1  asynchronous, active-high reset
btn_add  in  1  add-time button, synchronous level
btn_start  in  1  start/resume button, synchronous level
btn_stop  in  1  stop/pause button, synchronous level
door_open  in  1  door sensor, 1 = open
p_run  in  1  timer run flag from the downstream stage
tin  out  4  increment to timer; STEP for exactly one cycle per accepted add, else 0
r  out  1  run request to timer
beep  out  1  buzzer drive
timer_clr  out  1  one-cycle timer clear request (only with PANEL_CANCEL_EN, else tied 0)
state  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst=1): state=IDLE; tin=0, r=0, beep=0, timer_clr=0; shadow=0; beep counter=0; edge-detector history=0; seen_run=0.
- Buttons: act on rising edge only (registered previous value); a held button acts once. Edge is visible in the cycle after the level rises.
- Same-cycle priority: stop > start > add.
- shadow (4b): accepted add sets shadow = shadow + STEP. An add is rejected (tin stays 0) if shadow + STEP > MAX_SET; compute in 5 bits, no wrap.
- IDLE (0): add -> tin=STEP, update shadow, go to SET. start/stop ignored.
- SET (1): add -> saturating accept, stay. start with door_open=0 and shadow!=0 -> RUN, r=1 from the next cycle. start with door open -> ignored.
- RUN (2): r=1. Set seen_run when p_run=1 is sampled.
  - Falling edge of p_run with seen_run=1 -> DONE.
  - door_open=1 or stop edge -> PAUSE, r=0 from the next cycle.
  - A p_run fall in the same cycle as door/stop -> DONE wins.
  - Adds are ignored.
- PAUSE (3): r=0. start with door closed -> RUN. Adds are ignored.
- DONE (4):
  - On entry: r=0, beep=1, counter loaded with BEEP_CYCLES, shadow=0, seen_run=0.
  - beep drops and state returns to IDLE after exactly BEEP_CYCLES cycles.
  - Any button edge -> IDLE next cycle with beep=0 (acknowledge).
- Unused encodings 5-7 -> IDLE, all outputs 0.
- Reset mid-RUN: r drops asynchronously. The downstream timer is reset by its own rst.

Optional Feature:
PANEL_CANCEL_EN
- Defined: a stop edge in SET or PAUSE drives timer_clr=1 for one cycle, clears shadow, and goes to IDLE. A stop in RUN still pauses.
- Undefined: timer_clr is constant 0 and stop in SET/PAUSE is ignored.

Decomposition:
- Package microwave_pkg holds:
  - state encodings ST_IDLE=3'd0, ST_SET=1, ST_RUN=2, ST_PAUSE=3, ST_DONE=4;
  - 4-bit time width constant TIME_W=4;
  - default STEP and BEEP_CYCLES.
- Sub-module panel_edge_det: 1-bit registered rising-edge detector with async reset. Instantiated for btn_add, btn_start, btn_stop and p_run (falling edge derived from its history).

Test Plan:
- Reset then 3 add presses -> three 1-cycle tin=1 pulses, state=SET, shadow=3.
- 16 add presses -> 15 tin pulses; the 16th is rejected (tin stays 0, shadow stays 15).
- SET, start with door_open=1 -> stays SET, r=0. Close door, start -> r=1 next cycle, state=RUN.
- RUN, door_open=1 -> r=0 next cycle, state=PAUSE. Close door, start -> RUN.
- RUN, drive p_run 1 then 0 -> state=DONE, beep high for exactly 8 cycles, then IDLE. Repeat with a button pressed at beep cycle 3 -> IDLE and beep=0 next cycle.
- With PANEL_CANCEL_EN, SET plus stop -> timer_clr pulse 1 cycle, IDLE, shadow=0. Without it -> stays SET, timer_clr=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encodings, widths and defaults for the microwave front panel
package microwave_pkg;

    localparam int TIME_W = 4;
    localparam logic [TIME_W-1:0] STEP_DEF    = 4'd1;
    localparam logic [TIME_W-1:0] MAX_SET_DEF = 4'd15;
    localparam int BEEP_CYCLES_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Sum is formed one bit wider so a full shadow cannot wrap back to a small value.
    function automatic logic add_fits(input logic [TIME_W-1:0] shadow,
                                      input logic [TIME_W-1:0] step,
                                      input logic [TIME_W-1:0] max_set);
        logic [TIME_W:0] sum;
        sum = {1'b0, shadow} + {1'b0, step};
        return sum <= {1'b0, max_set};
    endfunction

endpackage

// File: rtl/microwave_panel_ctrl_if.sv
// rtl/microwave_panel_ctrl_if.sv - panel button/door inputs and timer-facing outputs
interface microwave_panel_ctrl_if;
    import microwave_pkg::*;

    logic              btn_add;
    logic              btn_start;
    logic              btn_stop;
    logic              door_open;
    logic              p_run;
    logic [TIME_W-1:0] tin;
    logic              r;
    logic              beep;
    logic              timer_clr;
    logic [2:0]        state;

    modport master (
        output btn_add, btn_start, btn_stop, door_open, p_run,
        input  tin, r, beep, timer_clr, state
    );

    modport slave (
        input  btn_add, btn_start, btn_stop, door_open, p_run,
        output tin, r, beep, timer_clr, state
    );

endinterface

// File: rtl/microwave_panel_ctrl_edge_det.sv
// rtl/microwave_panel_ctrl_edge_det.sv - registered rise/fall detector for one synchronous level
module panel_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            hist <= d;
            rise <= d & ~hist;
            fall <= ~d & hist;
        end
    end

endmodule

// File: rtl/microwave_panel_ctrl.sv
// rtl/microwave_panel_ctrl.sv - panel FSM driving timer increment, run request and beep; PANEL_CANCEL_EN adds stop-to-cancel
module microwave_panel_ctrl
    import microwave_pkg::*;
#(
    parameter logic [TIME_W-1:0] STEP        = STEP_DEF,
    parameter int                BEEP_CYCLES = BEEP_CYCLES_DEF,
    parameter logic [TIME_W-1:0] MAX_SET     = MAX_SET_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    microwave_panel_ctrl_if.slave  pif
);

    logic add_rise, start_rise, stop_rise, p_fall;
    logic add_fall_unused, start_fall_unused, stop_fall_unused, p_rise_unused;

    panel_edge_det u_add   (.clk(clk), .rst(rst), .d(pif.btn_add),   .rise(add_rise),      .fall(add_fall_unused));
    panel_edge_det u_start (.clk(clk), .rst(rst), .d(pif.btn_start), .rise(start_rise),    .fall(start_fall_unused));
    panel_edge_det u_stop  (.clk(clk), .rst(rst), .d(pif.btn_stop),  .rise(stop_rise),     .fall(stop_fall_unused));
    panel_edge_det u_prun  (.clk(clk), .rst(rst), .d(pif.p_run),     .rise(p_rise_unused), .fall(p_fall));

    state_t            st_q, st_n;
    logic [TIME_W-1:0] shadow_q, shadow_n, tin_q, tin_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              seen_q, seen_n;
    logic              r_q, r_n, beep_q, beep_n, clr_q, clr_n;
    logic              add_ok, cancel;

    assign add_ok = add_rise && add_fits(shadow_q, STEP, MAX_SET);

`ifdef PANEL_CANCEL_EN
    assign cancel = stop_rise;
`else
    assign cancel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            shadow_q <= '0;
            tin_q    <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            r_q      <= 1'b0;
            beep_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            st_q     <= st_n;
            shadow_q <= shadow_n;
            tin_q    <= tin_n;
            cnt_q    <= cnt_n;
            seen_q   <= seen_n;
            r_q      <= r_n;
            beep_q   <= beep_n;
            clr_q    <= clr_n;
        end
    end

    always_comb begin
        st_n     = st_q;
        shadow_n = shadow_q;
        cnt_n    = cnt_q;
        seen_n   = seen_q;
        tin_n    = '0;
        beep_n   = 1'b0;
        clr_n    = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (add_ok) begin
                    tin_n    = STEP;
                    shadow_n = shadow_q + STEP;
                    st_n     = ST_SET;
                end
            end
            ST_SET: begin
                if (cancel) begin
                    clr_n    = 1'b1;
                    shadow_n = '0;
                    seen_n   = 1'b0;
                    st_n     = ST_IDLE;
                end else if (start_rise && !pif.door_open && shadow_q != '0) begin
                    st_n = ST_RUN;
                end else if (add_ok) begin
                    tin_n    = STEP;
                    shadow_n = shadow_q + STEP;
                end
            end
            ST_RUN: begin
                if (pif.p_run) seen_n = 1'b1;
                // Completion outranks a pause request arriving in the same cycle.
                if (p_fall && seen_q) begin
                    st_n     = ST_DONE;
                    beep_n   = 1'b1;
                    cnt_n    = 8'(BEEP_CYCLES);
                    shadow_n = '0;
                    seen_n   = 1'b0;
                end else if (pif.door_open || stop_rise) begin
                    st_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (cancel) begin
                    clr_n    = 1'b1;
                    shadow_n = '0;
                    seen_n   = 1'b0;
                    st_n     = ST_IDLE;
                end else if (start_rise && !pif.door_open) begin
                    st_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (add_rise || start_rise || stop_rise || cnt_q <= 8'd1) begin
                    st_n  = ST_IDLE;
                    cnt_n = '0;
                end else begin
                    cnt_n  = cnt_q - 8'd1;
                    beep_n = 1'b1;
                end
            end
            default: begin
                st_n     = ST_IDLE;
                shadow_n = '0;
                seen_n   = 1'b0;
                cnt_n    = '0;
            end
        endcase
        r_n = (st_n == ST_RUN);
    end

    assign pif.tin       = tin_q;
    assign pif.r         = r_q;
    assign pif.beep      = beep_q;
    assign pif.timer_clr = clr_q;
    assign pif.state     = st_q;

endmodule
